// File: rtl/med_seq.sv
// Windowed median filter: collects NB_PIXEL pixels, then finds the median by
// repeated max-extraction, one compare per cycle. Bypass returns the centre pixel.
//   state   | meaning
//   LOAD    | accepting pixels, RDY=1
//   COMPUTE | max-extraction passes, RDY=0
module med_seq #(
  parameter int SIZE     = 8,
  parameter int NB_PIXEL = 9
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [SIZE-1:0] DI,
  input  logic            DSI,
  input  logic            BYP,
  output logic            RDY,
  output logic [SIZE-1:0] DO,
  output logic            DSO
);

  localparam int CW    = $clog2(NB_PIXEL) + 1;
  localparam int IW    = $clog2(NB_PIXEL);
  localparam int M_IDX = (NB_PIXEL - 1) / 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(NB_PIXEL - 1);
  localparam logic [CW-1:0] M_PASS   = CW'(M_IDX);

  typedef enum logic {LOAD, COMPUTE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   pass_q, pass_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            byp_q, byp_d;
  logic [SIZE-1:0] acc_q, acc_d;
  logic [IW-1:0]   acc_idx_q, acc_idx_d;
  logic [SIZE-1:0] do_q, do_d;
  logic            dso_q, dso_d;
  logic [SIZE-1:0] pix_q [NB_PIXEL];
  logic [SIZE-1:0] pix_d [NB_PIXEL];

  logic [SIZE-1:0] cand;
  logic            take;
  logic [SIZE-1:0] new_acc;
  logic [IW-1:0]   new_idx;
  logic [CW-1:0]   last;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      pass_q    <= '0;
      idx_q     <= '0;
      byp_q     <= 1'b0;
      acc_q     <= '0;
      acc_idx_q <= '0;
      do_q      <= '0;
      dso_q     <= 1'b0;
      pix_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      idx_q     <= idx_d;
      byp_q     <= byp_d;
      acc_q     <= acc_d;
      acc_idx_q <= acc_idx_d;
      do_q      <= do_d;
      dso_q     <= dso_d;
      pix_q     <= pix_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    idx_d     = idx_q;
    byp_d     = byp_q;
    acc_d     = acc_q;
    acc_idx_d = acc_idx_q;
    do_d      = do_q;
    dso_d     = 1'b0;
    pix_d     = pix_q;

    cand    = pix_q[idx_q[IW-1:0]];
    // strict compare keeps the earliest of equal maxima, so a tie removes one slot
    take    = (idx_q == '0) || (cand > acc_q);
    new_acc = take ? cand : acc_q;
    new_idx = take ? idx_q[IW-1:0] : acc_idx_q;
    last    = LAST_IDX - pass_q;

    case (state_q)
      LOAD: begin
        if (DSI) begin
          pix_d[cnt_q[IW-1:0]] = DI;
          if (cnt_q == '0) byp_d = BYP;
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            if (byp_q) begin
              do_d  = pix_q[M_IDX];
              dso_d = 1'b1;
            end else begin
              state_d = COMPUTE;
              pass_d  = '0;
              idx_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      COMPUTE: begin
        acc_d     = new_acc;
        acc_idx_d = new_idx;
        if (idx_q == last) begin
          idx_d = '0;
          if (pass_q == M_PASS) begin
            do_d    = new_acc;
            dso_d   = 1'b1;
            state_d = LOAD;
          end else begin
            // drop the max by overwriting it with the tail candidate; the live set shrinks by one
            pix_d[new_idx] = cand;
            pass_d         = pass_q + CW'(1);
          end
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign RDY = (state_q == LOAD) && !RST;
  assign DO  = do_q;
  assign DSO = dso_q;

endmodule

// File: tb/tb_med_seq.sv
// Bench for med_seq: directed window table, reset/back-to-back sequences, and
// randomized windows scored against a sort-free rank-based median model.
module tb_med_seq;

  localparam int C_A = 35;
  localparam int C_B = 5;

  typedef struct {
    int val;
    int t0;
    int lat;
  } exp_t;

  typedef struct {
    int pix[9];
    bit byp;
    int exp;
  } vec_t;

  logic        CLK = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        RST_a, DSI_a, BYP_a, RDY_a, DSO_a;
  logic [7:0]  DI_a, DO_a;
  logic        RST_b, DSI_b, BYP_b, RDY_b, DSO_b;
  logic [11:0] DI_b, DO_b;

  exp_t qa[$];
  exp_t qb[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  med_seq #(.SIZE(8), .NB_PIXEL(9)) dut_a (
    .CLK(CLK), .RST(RST_a), .DI(DI_a), .DSI(DSI_a), .BYP(BYP_a),
    .RDY(RDY_a), .DO(DO_a), .DSO(DSO_a)
  );

  med_seq #(.SIZE(12), .NB_PIXEL(3)) dut_b (
    .CLK(CLK), .RST(RST_b), .DI(DI_b), .DSI(DSI_b), .BYP(BYP_b),
    .RDY(RDY_b), .DO(DO_b), .DSO(DSO_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // median = the element with at most m values strictly below it and more than m at or below it
  function automatic int ref_result(input int p[9], input int n, input bit byp);
    int m;
    int lt;
    int le;
    m = (n - 1) / 2;
    if (byp) return p[m];
    for (int i = 0; i < n; i++) begin
      lt = 0;
      le = 0;
      for (int j = 0; j < n; j++) begin
        if (p[j] < p[i]) lt++;
        if (p[j] <= p[i]) le++;
      end
      if (lt <= m && le > m) return p[i];
    end
    return -1;
  endfunction

  task automatic push_a(input int d, input bit byp, input bit noise);
    bit done;
    int k;
    done = 1'b0;
    k = 0;
    while (!done) begin
      @(negedge CLK); #1;
      if (RDY_a) begin
        DI_a = 8'(d); BYP_a = byp; DSI_a = 1'b1; done = 1'b1;
      end else begin
        DSI_a = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        DI_a  = 8'($urandom);
        BYP_a = 1'($urandom_range(0, 1));
        k++;
        if (k > 200) begin
          chk("push_a_timeout", k, 0);
          return;
        end
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic push_b(input int d, input bit byp, input bit noise);
    bit done;
    int k;
    done = 1'b0;
    k = 0;
    while (!done) begin
      @(negedge CLK); #1;
      if (RDY_b) begin
        DI_b = 12'(d); BYP_b = byp; DSI_b = 1'b1; done = 1'b1;
      end else begin
        DSI_b = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        DI_b  = 12'($urandom);
        BYP_b = 1'($urandom_range(0, 1));
        k++;
        if (k > 200) begin
          chk("push_b_timeout", k, 0);
          return;
        end
      end
    end
    @(posedge CLK); #1;
  endtask

  // BYP is driven inverted on pixels 1.. so a window only follows its pixel-0 mode
  task automatic send_a(input int p[9], input bit byp, input int gap_max, input bit noise,
                        output int t0);
    int g;
    for (int i = 0; i < 9; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        @(negedge CLK); #1;
        DSI_a = 1'b0; DI_a = 8'($urandom); BYP_a = 1'($urandom_range(0, 1));
      end
      push_a(p[i], (i == 0) ? byp : !byp, noise);
    end
    t0 = cyc;
  endtask

  task automatic send_b(input int p[9], input bit byp, input int gap_max, output int t0);
    int g;
    for (int i = 0; i < 3; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        @(negedge CLK); #1;
        DSI_b = 1'b0; DI_b = 12'($urandom); BYP_b = 1'($urandom_range(0, 1));
      end
      push_b(p[i], (i == 0) ? byp : !byp, 1'b1);
    end
    t0 = cyc;
  endtask

  task automatic expect_a(input int val, input int t0, input bit byp);
    exp_t e;
    e.val = val; e.t0 = t0; e.lat = byp ? 0 : C_A;
    qa.push_back(e);
  endtask

  task automatic expect_b(input int val, input int t0, input bit byp);
    exp_t e;
    e.val = val; e.t0 = t0; e.lat = byp ? 0 : C_B;
    qb.push_back(e);
  endtask

  task automatic drain(input bit which);
    int k;
    k = 0;
    while (((which ? qb.size() : qa.size()) > 0) && k < 100) begin
      @(negedge CLK);
      k++;
    end
    @(negedge CLK);
    if ((which ? qb.size() : qa.size()) > 0) begin
      chk(which ? "drain_b_timeout" : "drain_a_timeout", which ? qb.size() : qa.size(), 0);
      if (which) qb.delete(); else qa.delete();
    end
  endtask

  task automatic mon_a();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (DSO_a) begin
        if (qa.size() == 0) chk("dso_a_unexpected", 1, 0);
        else begin
          e = qa.pop_front();
          chk("do_a", int'(DO_a), e.val);
          chk("lat_a", cyc - e.t0, e.lat);
          chk("rdy_a_at_dso", int'(RDY_a), 1);
        end
      end else if (qa.size() > 0 && qa[0].lat > 0 && (cyc - qa[0].t0) < qa[0].lat) begin
        chk("rdy_a_compute", int'(RDY_a), 0);
      end
    end
  endtask

  task automatic mon_b();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (DSO_b) begin
        if (qb.size() == 0) chk("dso_b_unexpected", 1, 0);
        else begin
          e = qb.pop_front();
          chk("do_b", int'(DO_b), e.val);
          chk("lat_b", cyc - e.t0, e.lat);
        end
      end else if (qb.size() > 0 && qb[0].lat > 0 && (cyc - qb[0].t0) < qb[0].lat) begin
        chk("rdy_b_compute", int'(RDY_b), 0);
      end
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   p[9];
    int   t0;
    int   t0s[3];
    bit   byp;

    vecs[0] = '{'{10, 20, 30, 40, 50, 60, 70, 80, 90}, 1'b0, 50};
    vecs[1] = '{'{90, 80, 70, 60, 50, 40, 30, 20, 10}, 1'b0, 50};
    vecs[2] = '{'{7, 7, 7, 1, 1, 200, 200, 200, 3}, 1'b0, 7};
    vecs[3] = '{'{0, 255, 0, 255, 0, 255, 0, 255, 255}, 1'b0, 255};
    vecs[4] = '{'{0, 255, 3, 100, 42, 8, 9, 1, 2}, 1'b0, 8};
    vecs[5] = '{'{0, 255, 3, 100, 42, 8, 9, 1, 2}, 1'b1, 42};
    vecs[6] = '{'{5, 4, 3, 2, 1, 9, 8, 7, 6}, 1'b0, 5};
    vecs[7] = '{'{1, 2, 3, 4, 250, 6, 7, 8, 9}, 1'b1, 250};

    RST_a = 1'b1; DSI_a = 1'b0; BYP_a = 1'b0; DI_a = '0;
    RST_b = 1'b1; DSI_b = 1'b0; BYP_b = 1'b0; DI_b = '0;

    fork
      mon_a();
      mon_b();
    join_none

    repeat (3) @(negedge CLK);
    chk("rst_rdy_a", int'(RDY_a), 0);
    chk("rst_do_a", int'(DO_a), 0);
    chk("rst_dso_a", int'(DSO_a), 0);
    chk("rst_rdy_b", int'(RDY_b), 0);
    chk("rst_do_b", int'(DO_b), 0);
    #1;
    RST_a = 1'b0; RST_b = 1'b0;
    @(negedge CLK);
    chk("post_rst_rdy_a", int'(RDY_a), 1);
    chk("post_rst_rdy_b", int'(RDY_b), 1);

    for (int v = 0; v < 8; v++) begin
      send_a(vecs[v].pix, vecs[v].byp, 0, 1'b0, t0);
      DSI_a = 1'b0;
      expect_a(vecs[v].exp, t0, vecs[v].byp);
      drain(1'b0);
    end

    // three windows with DSI never dropping: period must be exactly NB_PIXEL + C
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 9; i++) p[i] = int'($urandom_range(0, 255));
      send_a(p, 1'b0, 0, 1'b0, t0);
      t0s[w] = t0;
      expect_a(ref_result(p, 9, 1'b0), t0, 1'b0);
    end
    DSI_a = 1'b0;
    drain(1'b0);
    chk("b2b_period_1", t0s[1] - t0s[0], 9 + C_A);
    chk("b2b_period_2", t0s[2] - t0s[1], 9 + C_A);

    // reset in the middle of a compute
    send_a(vecs[0].pix, 1'b0, 0, 1'b0, t0);
    DSI_a = 1'b0;
    repeat (17) @(negedge CLK);
    #1 RST_a = 1'b1;
    @(negedge CLK); #1;
    chk("rst_mid_rdy_low", int'(RDY_a), 0);
    RST_a = 1'b0;
    #1;
    chk("rst_mid_do", int'(DO_a), 0);
    chk("rst_mid_dso", int'(DSO_a), 0);
    chk("rst_mid_rdy", int'(RDY_a), 1);
    repeat (45) @(negedge CLK);
    send_a(vecs[6].pix, 1'b0, 0, 1'b0, t0);
    DSI_a = 1'b0;
    expect_a(5, t0, 1'b0);
    drain(1'b0);

    // reset with a partial window loaded
    for (int i = 0; i < 4; i++) push_a(200, 1'b1, 1'b0);
    DSI_a = 1'b0;
    @(negedge CLK); #1 RST_a = 1'b1;
    @(negedge CLK); #1 RST_a = 1'b0;
    chk("rst_load_do", int'(DO_a), 0);
    send_a(vecs[0].pix, 1'b0, 0, 1'b0, t0);
    DSI_a = 1'b0;
    expect_a(50, t0, 1'b0);
    drain(1'b0);

    for (int w = 0; w < 150; w++) begin
      for (int i = 0; i < 9; i++)
        p[i] = (w % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      byp = ($urandom_range(0, 3) == 0);
      send_a(p, byp, 5, 1'b1, t0);
      expect_a(ref_result(p, 9, byp), t0, byp);
    end
    DSI_a = 1'b0;
    drain(1'b0);

    for (int i = 0; i < 9; i++) p[i] = 0;
    for (int w = 0; w < 1000; w++) begin
      for (int i = 0; i < 3; i++)
        p[i] = (w % 4 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 4095));
      byp = ($urandom_range(0, 4) == 0);
      send_b(p, byp, 2, t0);
      expect_b(ref_result(p, 3, byp), t0, byp);
    end
    DSI_b = 1'b0;
    drain(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
